calc_frontend_fsm: RTL

- Parametrised keypad-to-CPU calculator front end: collects two multi-digit decimal operands and an operator from decoded keypad events, then writes them to CPU-visible memory-mapped addresses.
- Hands control to the CPU and waits for completion with a timeout, then reads the result and converts it to BCD for the seven-segment and LCD drivers.
- Sits between the keypad/edge-detect logic and the CPU data bus; replaces the fixed 2-digit front end.

---
 rtl/calc_pkg.sv | 59 +++++
 rtl/bin_to_bcd_seq.sv | 86 ++++++++
 rtl/calc_frontend_fsm.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator front end.
// Holds the state encoding, keypad codes, operator encodings,
// default bus addresses and small key-decoding helpers.
package calc_pkg;

    // State encoding is visible on state_o, so the values are fixed.
    typedef enum logic [3:0] {
        ST_NUM1     = 4'd0,
        ST_OPSEL    = 4'd1,
        ST_NUM2     = 4'd2,
        ST_WR_OP1   = 4'd3,
        ST_WR_OPC   = 4'd4,
        ST_WR_OP2   = 4'd5,
        ST_WAIT_CPU = 4'd6,
        ST_READ     = 4'd7,
        ST_CONVERT  = 4'd8,
        ST_DISPLAY  = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    localparam logic [3:0] KEY_ADD   = 4'hA;
    localparam logic [3:0] KEY_SUB   = 4'hB;
    localparam logic [3:0] KEY_MUL   = 4'hC;
    localparam logic [3:0] KEY_DIV   = 4'hD;
    localparam logic [3:0] KEY_CLR   = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    localparam logic [31:0] DEF_OP1_ADDR  = 32'd220;
    localparam logic [31:0] DEF_OP2_ADDR  = 32'd240;
    localparam logic [31:0] DEF_OPC_ADDR  = 32'd260;
    localparam logic [31:0] DEF_RES_ADDR  = 32'd280;
    localparam logic [31:0] DEF_IDLE_ADDR = 32'd320;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    function automatic op_e key_to_op(input logic [3:0] k);
        op_e op;
        case (k)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load bin and begin conversion (ignored while busy)
//   bin   [DATA_W]  binary value to convert
//   busy            conversion in progress
//   done            one-cycle pulse; bcd/ovf are valid on this cycle
//   bcd   [4*NDIG]  low NDIG BCD digits of the result
//   ovf             result needs more than NDIG digits
module bin_to_bcd_seq #(
    parameter int DATA_W = 32,
    parameter int NDIG   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   bin,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd,
    output logic                ovf
);

    // Enough digits to hold any DATA_W-bit value, so overflow can be
    // seen as a non-zero digit above the NDIG visible ones.
    localparam int FULL_DIG = DATA_W / 3 + 1;
    localparam int WDIG     = (FULL_DIG > NDIG) ? FULL_DIG : NDIG;
    localparam int CNT_W    = $clog2(DATA_W + 1);

    logic [4*WDIG-1:0] bcd_q;
    logic [4*WDIG-1:0] bcd_adj;
    logic [DATA_W-1:0] bin_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;

    // Digits of 5 or more get +3 before the shift so they carry correctly.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < WDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        ovf = 1'b0;
        for (int i = NDIG; i < WDIG; i++) begin
            ovf = ovf | (bcd_q[4*i +: 4] != 4'd0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                bcd_q <= {bcd_adj[4*WDIG-2:0], bin_q[DATA_W-1]};
                bin_q <= {bin_q[DATA_W-2:0], 1'b0};
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start) begin
                bin_q  <= bin;
                bcd_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q[4*NDIG-1:0];

endmodule

// File: rtl/calc_frontend_fsm.sv
// Keypad-to-CPU calculator front end.
// Collects two decimal operands and an operator from keypad events, writes
// them to the CPU's memory-mapped addresses, waits for the CPU (with a
// timeout), reads the result back and converts it to BCD for display.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   key_valid, key_code[4]   decoded key event (0-9 digit, A-D op, E clr, F enter)
//   cpu_done                 CPU completion pulse
//   read_data[DATA_W]        bus read data, valid a cycle after the address
//   address[32]              bus address (IDLE_ADDR when idle)
//   write_data[DATA_W]       bus write data
//   fpga_write               bus write strobe
//   cpu_enable               high while waiting on the CPU
//   disp_bcd[8*DIGITS]       BCD for the display (operand or result)
//   disp_op[2]               latched operator
//   state_o[4]               current state
//   error                    sticky CPU timeout flag
module calc_frontend_fsm
    import calc_pkg::*;
#(
    parameter int          DIGITS    = 4,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] OP1_ADDR  = DEF_OP1_ADDR,
    parameter logic [31:0] OPC_ADDR  = DEF_OPC_ADDR,
    parameter logic [31:0] OP2_ADDR  = DEF_OP2_ADDR,
    parameter logic [31:0] RES_ADDR  = DEF_RES_ADDR,
    parameter logic [31:0] IDLE_ADDR = DEF_IDLE_ADDR,
    parameter int          TIMEOUT   = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  cpu_done,
    input  logic [DATA_W-1:0]     read_data,
    output logic [31:0]           address,
    output logic [DATA_W-1:0]     write_data,
    output logic                  fpga_write,
    output logic                  cpu_enable,
    output logic [4*DIGITS*2-1:0] disp_bcd,
    output logic [1:0]            disp_op,
    output logic [3:0]            state_o,
    output logic                  error
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int DISP_W = 2 * BCD_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  DIG_MAX = CNT_W'(DIGITS);
    localparam logic [TMR_W-1:0]  TMR_TOP = TMR_W'(TIMEOUT - 1);
    localparam logic [DISP_W-1:0] DISP_SAT  = {(2*DIGITS){4'h9}};
    localparam logic [DISP_W-1:0] DISP_DASH = {(2*DIGITS){4'hF}};

    state_e             state_q,   state_d;
    logic [BCD_W-1:0]   op1_bcd_q, op1_bcd_d, op2_bcd_q, op2_bcd_d;
    logic [DATA_W-1:0]  op1_bin_q, op1_bin_d, op2_bin_q, op2_bin_d;
    logic [CNT_W-1:0]   op1_cnt_q, op1_cnt_d, op2_cnt_q, op2_cnt_d;
    op_e                op_q,      op_d;
    logic               err_q,     err_d;
    logic [TMR_W-1:0]   tmr_q,     tmr_d;
    logic               rd_cnt_q,  rd_cnt_d;
    logic [DISP_W-1:0]  disp_q,    disp_d;

    logic               conv_start, conv_busy, conv_done, conv_ovf;
    logic [DISP_W-1:0]  conv_bcd;

    function automatic logic [DATA_W-1:0] acc_step(input logic [DATA_W-1:0] acc,
                                                   input logic [3:0]        d);
        return (acc << 3) + (acc << 1) + {{(DATA_W-4){1'b0}}, d};
    endfunction

    bin_to_bcd_seq #(
        .DATA_W (DATA_W),
        .NDIG   (2*DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (read_data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_NUM1;
            op1_bcd_q <= '0;
            op1_bin_q <= '0;
            op1_cnt_q <= '0;
            op2_bcd_q <= '0;
            op2_bin_q <= '0;
            op2_cnt_q <= '0;
            op_q      <= OP_ADD;
            err_q     <= 1'b0;
            tmr_q     <= '0;
            rd_cnt_q  <= 1'b0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            op1_bcd_q <= op1_bcd_d;
            op1_bin_q <= op1_bin_d;
            op1_cnt_q <= op1_cnt_d;
            op2_bcd_q <= op2_bcd_d;
            op2_bin_q <= op2_bin_d;
            op2_cnt_q <= op2_cnt_d;
            op_q      <= op_d;
            err_q     <= err_d;
            tmr_q     <= tmr_d;
            rd_cnt_q  <= rd_cnt_d;
            disp_q    <= disp_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        op1_bcd_d  = op1_bcd_q;
        op1_bin_d  = op1_bin_q;
        op1_cnt_d  = op1_cnt_q;
        op2_bcd_d  = op2_bcd_q;
        op2_bin_d  = op2_bin_q;
        op2_cnt_d  = op2_cnt_q;
        op_d       = op_q;
        err_d      = err_q;
        tmr_d      = tmr_q;
        rd_cnt_d   = rd_cnt_q;
        disp_d     = disp_q;
        conv_start = 1'b0;
        address    = IDLE_ADDR;
        write_data = '0;
        fpga_write = 1'b0;
        cpu_enable = 1'b0;

        case (state_q)
            ST_NUM1: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (op1_cnt_q < DIG_MAX) begin
                            op1_bcd_d = BCD_W'({op1_bcd_q, key_code});
                            op1_bin_d = acc_step(op1_bin_q, key_code);
                            op1_cnt_d = op1_cnt_q + 1'b1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        state_d = ST_OPSEL;
                    end else if (key_code == KEY_CLR) begin
                        op1_bcd_d = '0;
                        op1_bin_d = '0;
                        op1_cnt_d = '0;
                    end
                end
            end
            ST_OPSEL: begin
                // The operator stays latched until enter; add is the default.
                if (key_valid) begin
                    if (is_op(key_code)) begin
                        op_d = key_to_op(key_code);
                    end else if (key_code == KEY_ENTER) begin
                        state_d = ST_NUM2;
                    end else if (key_code == KEY_CLR) begin
                        op_d = OP_ADD;
                    end
                end
            end
            ST_NUM2: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (op2_cnt_q < DIG_MAX) begin
                            op2_bcd_d = BCD_W'({op2_bcd_q, key_code});
                            op2_bin_d = acc_step(op2_bin_q, key_code);
                            op2_cnt_d = op2_cnt_q + 1'b1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        state_d = ST_WR_OP1;
                    end else if (key_code == KEY_CLR) begin
                        op2_bcd_d = '0;
                        op2_bin_d = '0;
                        op2_cnt_d = '0;
                    end
                end
            end
            ST_WR_OP1: begin
                address    = OP1_ADDR;
                write_data = op1_bin_q;
                fpga_write = 1'b1;
                state_d    = ST_WR_OPC;
            end
            ST_WR_OPC: begin
                address    = OPC_ADDR;
                write_data = {{(DATA_W-2){1'b0}}, op_q};
                fpga_write = 1'b1;
                state_d    = ST_WR_OP2;
            end
            ST_WR_OP2: begin
                address    = OP2_ADDR;
                write_data = op2_bin_q;
                fpga_write = 1'b1;
                tmr_d      = '0;
                state_d    = ST_WAIT_CPU;
            end
            ST_WAIT_CPU: begin
                cpu_enable = 1'b1;
                // Completion on the final timer cycle still counts as success.
                if (cpu_done) begin
                    rd_cnt_d = 1'b0;
                    state_d  = ST_READ;
                end else if (tmr_q == TMR_TOP) begin
                    err_d   = 1'b1;
                    disp_d  = DISP_DASH;
                    state_d = ST_DISPLAY;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_READ: begin
                // First cycle presents the address; read_data is valid on the
                // second and is captured by the converter on its start.
                address = RES_ADDR;
                if (!rd_cnt_q) begin
                    rd_cnt_d = 1'b1;
                end else if (!conv_busy) begin
                    conv_start = 1'b1;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    disp_d  = conv_ovf ? DISP_SAT : conv_bcd;
                    state_d = ST_DISPLAY;
                end
            end
            ST_DISPLAY: begin
                if (key_valid && (key_code == KEY_ENTER || key_code == KEY_CLR)) begin
                    op1_bcd_d = '0;
                    op1_bin_d = '0;
                    op1_cnt_d = '0;
                    op2_bcd_d = '0;
                    op2_bin_d = '0;
                    op2_cnt_d = '0;
                    op_d      = OP_ADD;
                    err_d     = 1'b0;
                    state_d   = ST_NUM1;
                end
            end
            default: begin
                state_d = ST_NUM1;
            end
        endcase

        // Entry states show the operand being edited, one cycle after the key.
        if (state_d == ST_NUM1 || state_d == ST_OPSEL) begin
            disp_d = {{BCD_W{1'b0}}, op1_bcd_d};
        end else if (state_d == ST_NUM2) begin
            disp_d = {{BCD_W{1'b0}}, op2_bcd_d};
        end
    end

    assign disp_bcd = disp_q;
    assign disp_op  = op_q;
    assign state_o  = state_q;
    assign error    = err_q;

endmodule
